noc_output_port_arbiter: RTL and testbench

// - Shares one switch output link between NUM_INPUTS input ports under wormhole switching.
// - Round-robin grant on head flits; holds the grant until the tail flit has been forwarded.
// - Obeys STALL/GO backpressure from downstream and drives a registered flit/valid stage onto the link.

---
 rtl/noc_output_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_noc_output_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_output_port_arbiter.sv
// noc_output_port_arbiter
//   Shares one switch output link between NUM_INPUTS input ports under wormhole
//   switching. A round-robin choice is made among inputs showing a head flit.
//   The winner keeps the link until its tail flit has been forwarded. Flits go
//   onto the link through a registered flit/valid/tail stage. Downstream STALL
//   (stall_in = 1) freezes both that stage and the input handshake.
//
// Optional feature: define ARB_PKT_COUNT_EN to add the pkt_count port. It is a
// wrapping counter of forwarded tail flits.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   req_valid  [NUM_INPUTS]            flit present at input i
//   req_flit   [NUM_INPUTS*FLITWIDTH]  flit of input i at [i*FLITWIDTH +: FLITWIDTH]
//   req_head   [NUM_INPUTS]            flit of input i is a head flit
//   req_tail   [NUM_INPUTS]            flit of input i is a tail flit
//   req_ready  [NUM_INPUTS]            flit of input i is consumed this cycle
//   stall_in   downstream STALL (1) / GO (0)
//   out_flit   [FLITWIDTH]             registered flit to the link
//   out_valid  out_flit is valid
//   out_tail   out_flit is a tail flit
//   grant      [NUM_INPUTS]            one-hot owner of the link, 0 when idle
//   busy       a packet currently owns the link
//   pkt_count  [CNTW]                  forwarded-tail counter (ARB_PKT_COUNT_EN only)
module noc_output_port_arbiter #(
    parameter int NUM_INPUTS = 4,
    parameter int FLITWIDTH  = 32,
    parameter int CNTW       = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_INPUTS-1:0]           req_valid,
    input  logic [NUM_INPUTS*FLITWIDTH-1:0] req_flit,
    input  logic [NUM_INPUTS-1:0]           req_head,
    input  logic [NUM_INPUTS-1:0]           req_tail,
    output logic [NUM_INPUTS-1:0]           req_ready,
    input  logic                            stall_in,
    output logic [FLITWIDTH-1:0]            out_flit,
    output logic                            out_valid,
    output logic                            out_tail,
    output logic [NUM_INPUTS-1:0]           grant,
    output logic                            busy
`ifdef ARB_PKT_COUNT_EN
    ,
    output logic [CNTW-1:0]                 pkt_count
`endif
);

    localparam int IDXW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                state, state_next;
    logic [IDXW-1:0]       ptr;       // index of the last input served
    logic [IDXW-1:0]       gidx;      // index of the current owner
    logic [NUM_INPUTS-1:0] eligible;
    logic                  any_elig;
    logic [IDXW-1:0]       pick;
    logic [NUM_INPUTS-1:0] pick_oh;
    logic [IDXW-1:0]       cand;
    logic                  found;
    logic                  xfer;
    logic                  tail_xfer;

    assign eligible  = req_valid & req_head;
    assign any_elig  = |eligible;
    assign busy      = (state == LOCKED);
    assign req_ready = (state == LOCKED && !stall_in) ? grant : '0;
    assign xfer      = (state == LOCKED) && !stall_in && req_valid[gidx];
    assign tail_xfer = xfer && req_tail[gidx];

    // Round-robin scan starting one past the last served input
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            cand = IDXW'((int'(ptr) + k) % NUM_INPUTS);
            if (!found && eligible[cand]) begin
                found         = 1'b1;
                pick          = cand;
                pick_oh       = '0;
                pick_oh[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_elig)  state_next = LOCKED;
            LOCKED:  if (tail_xfer) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Ownership and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= '0;
            gidx  <= '0;
            ptr   <= IDXW'(NUM_INPUTS - 1);
        end else if (state == IDLE && any_elig) begin
            grant <= pick_oh;
            gidx  <= pick;
        end else if (tail_xfer) begin
            grant <= '0;
            ptr   <= gidx;
        end
    end

    // Link output stage: frozen while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            out_flit  <= '0;
            out_valid <= 1'b0;
            out_tail  <= 1'b0;
        end else if (!stall_in) begin
            if (xfer) begin
                out_flit  <= req_flit[int'(gidx)*FLITWIDTH +: FLITWIDTH];
                out_tail  <= req_tail[gidx];
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
                out_tail  <= 1'b0;
            end
        end
    end

`ifdef ARB_PKT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)            pkt_count <= '0;
        else if (tail_xfer) pkt_count <= pkt_count + CNTW'(1);
    end
`endif

endmodule

// File: tb/tb_noc_output_port_arbiter.sv
// Directed bench for noc_output_port_arbiter: single packet, round-robin
// contention, wormhole hold, backpressure, reset mid-packet, non-head idle
// flits and (with ARB_PKT_COUNT_EN) the wrapping packet counter.
module tb_noc_output_port_arbiter;

    localparam int N  = 4;
    localparam int FW = 32;
`ifdef ARB_PKT_COUNT_EN
    localparam int CW = 4;
`endif

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*FW-1:0] req_flit;
    logic [N-1:0]    req_head;
    logic [N-1:0]    req_tail;
    logic [N-1:0]    req_ready;
    logic            stall_in;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_tail;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef ARB_PKT_COUNT_EN
    logic [CW-1:0]   pkt_count;
`endif

    noc_output_port_arbiter #(
        .NUM_INPUTS(N),
        .FLITWIDTH (FW)
`ifdef ARB_PKT_COUNT_EN
        ,
        .CNTW      (CW)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_flit  (req_flit),
        .req_head  (req_head),
        .req_tail  (req_tail),
        .req_ready (req_ready),
        .stall_in  (stall_in),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .out_tail  (out_tail),
        .grant     (grant),
        .busy      (busy)
`ifdef ARB_PKT_COUNT_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic v, input logic h, input logic t,
                         input logic [FW-1:0] f);
        req_valid[i]          = v;
        req_head[i]           = h;
        req_tail[i]           = t;
        req_flit[i*FW +: FW]  = f;
    endtask

    task automatic clear_all();
        req_valid = '0;
        req_head  = '0;
        req_tail  = '0;
        req_flit  = '0;
        stall_in  = 1'b0;
    endtask

    task automatic do_reset();
        clear_all();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic t, input logic [FW-1:0] f);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".tail"},  32'(out_tail),  32'(t));
        if (v) chk({tag, ".flit"}, out_flit, f);
    endtask

    initial begin
        rst = 1'b0;
        clear_all();
        do_reset();

        // Reset state
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.busy",  32'(busy), 32'h0);
        chk_out("rst", 1'b0, 1'b0, 32'h0);
        chk("rst.flit",  out_flit, 32'h0);

        // Single requester: in0 sends A0,A1,A2(tail)
        drive(0, 1'b1, 1'b1, 1'b0, 32'hA000_0000);
        #1 chk("t1.ready_idle", 32'(req_ready), 32'h0);
        tick();
        chk("t1.grant", 32'(grant), 32'h1);
        chk("t1.busy", 32'(busy), 32'h1);
        chk("t1.nv", 32'(out_valid), 32'h0);
        #1 chk("t1.ready", 32'(req_ready), 32'h1);
        tick();
        chk_out("t1.A0", 1'b1, 1'b0, 32'hA000_0000);
        drive(0, 1'b1, 1'b0, 1'b0, 32'hA000_0001);
        tick();
        chk_out("t1.A1", 1'b1, 1'b0, 32'hA000_0001);
        drive(0, 1'b1, 1'b0, 1'b1, 32'hA000_0002);
        tick();
        chk_out("t1.A2", 1'b1, 1'b1, 32'hA000_0002);
        chk("t1.busy_drop", 32'(busy), 32'h0);
        chk("t1.grant_drop", 32'(grant), 32'h0);
        clear_all();
        tick();
        chk("t1.after", 32'(out_valid), 32'h0);

        // Contention: four 1-flit packets, served 0,1,2,3
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b1, 1'b1, 32'hF000_0000 + 32'(i));
        for (int k = 0; k < N; k++) begin
            tick();
            chk($sformatf("t2.grant%0d", k), 32'(grant), 32'(1) << k);
            tick();
            chk_out($sformatf("t2.out%0d", k), 1'b1, 1'b1, 32'hF000_0000 + 32'(k));
            chk($sformatf("t2.idle%0d", k), 32'(grant), 32'h0);
            drive(k, 1'b0, 1'b0, 1'b0, 32'h0);
        end
        // Re-request from in0 and in2 with pointer at 3
        drive(0, 1'b1, 1'b1, 1'b1, 32'hB0B0_0000);
        drive(2, 1'b1, 1'b1, 1'b1, 32'hB0B0_0002);
        tick();
        chk("t2.re0", 32'(grant), 32'h1);
        tick();
        chk_out("t2.re0out", 1'b1, 1'b1, 32'hB0B0_0000);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("t2.re2", 32'(grant), 32'h4);
        tick();
        chk_out("t2.re2out", 1'b1, 1'b1, 32'hB0B0_0002);
        clear_all();

        // Wormhole hold: in1 pauses mid-packet while in2 waits with a head
        drive(1, 1'b1, 1'b1, 1'b0, 32'hB100_0000);
        tick();
        chk("t3.grant", 32'(grant), 32'h2);
        tick();
        chk_out("t3.B0", 1'b1, 1'b0, 32'hB100_0000);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        drive(2, 1'b1, 1'b1, 1'b1, 32'hC000_0000);
        for (int h = 0; h < 3; h++) begin
            if (h > 0) chk($sformatf("t3.gap_nv%0d", h), 32'(out_valid), 32'h0);
            #1;
            chk($sformatf("t3.hold%0d", h), 32'(grant), 32'h2);
            chk($sformatf("t3.ready%0d", h), 32'(req_ready), 32'h2);
            tick();
        end
        chk("t3.still", 32'(grant), 32'h2);
        drive(1, 1'b1, 1'b0, 1'b1, 32'hB100_0001);
        tick();
        chk_out("t3.B1", 1'b1, 1'b1, 32'hB100_0001);
        chk("t3.release", 32'(grant), 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("t3.in2", 32'(grant), 32'h4);
        tick();
        chk_out("t3.C0", 1'b1, 1'b1, 32'hC000_0000);
        clear_all();

        // Backpressure: stall mid-packet, stream must resume intact
        drive(3, 1'b1, 1'b1, 1'b0, 32'hD000_0000);
        tick();
        chk("t4.grant", 32'(grant), 32'h8);
        tick();
        chk_out("t4.D0", 1'b1, 1'b0, 32'hD000_0000);
        drive(3, 1'b1, 1'b0, 1'b0, 32'hD000_0001);
        tick();
        chk_out("t4.D1", 1'b1, 1'b0, 32'hD000_0001);
        drive(3, 1'b1, 1'b0, 1'b0, 32'hD000_0002);
        stall_in = 1'b1;
        for (int s = 0; s < 4; s++) begin
            if (s > 0) tick();
            #1;
            chk($sformatf("t4.sready%0d", s), 32'(req_ready), 32'h0);
            chk_out($sformatf("t4.shold%0d", s), 1'b1, 1'b0, 32'hD000_0001);
            chk($sformatf("t4.sgrant%0d", s), 32'(grant), 32'h8);
        end
        tick();
        stall_in = 1'b0;
        chk_out("t4.held", 1'b1, 1'b0, 32'hD000_0001);
        #1 chk("t4.ready", 32'(req_ready), 32'h8);
        tick();
        chk_out("t4.D2", 1'b1, 1'b0, 32'hD000_0002);
        drive(3, 1'b1, 1'b0, 1'b1, 32'hD000_0003);
        tick();
        chk_out("t4.D3", 1'b1, 1'b1, 32'hD000_0003);
        chk("t4.busy", 32'(busy), 32'h0);
        clear_all();
        tick();

        // Reset mid-packet on in3
        drive(3, 1'b1, 1'b1, 1'b0, 32'hE000_0000);
        tick();
        chk("t5.grant", 32'(grant), 32'h8);
        tick();
        chk_out("t5.E0", 1'b1, 1'b0, 32'hE000_0000);
        rst = 1'b1;
        drive(3, 1'b1, 1'b0, 1'b0, 32'hE000_0001);
        tick();
        rst = 1'b0;
        chk("t5.grant0", 32'(grant), 32'h0);
        chk("t5.busy0", 32'(busy), 32'h0);
        chk("t5.valid0", 32'(out_valid), 32'h0);
        chk("t5.flit0", out_flit, 32'h0);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h6000_0000);
        drive(3, 1'b1, 1'b1, 1'b0, 32'hE000_0000);
        tick();
        chk("t5.in0first", 32'(grant), 32'h1);
        tick();
        chk_out("t5.G0", 1'b1, 1'b1, 32'h6000_0000);
        clear_all();
        tick();

        // Non-head flit at an idle input is never eligible
        drive(1, 1'b1, 1'b0, 1'b0, 32'h7777_7777);
        tick();
        tick();
        chk("t6.grant", 32'(grant), 32'h0);
        chk("t6.busy", 32'(busy), 32'h0);
        #1 chk("t6.ready", 32'(req_ready), 32'h0);
        clear_all();

        // Stall during IDLE does not block arbitration
        stall_in = 1'b1;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h5555_0000);
        tick();
        chk("t7.grant", 32'(grant), 32'h4);
        chk("t7.ready", 32'(req_ready), 32'h0);
        stall_in = 1'b0;
        tick();
        chk_out("t7.out", 1'b1, 1'b1, 32'h5555_0000);
        clear_all();

`ifdef ARB_PKT_COUNT_EN
        // 17 one-flit packets wrap a 4-bit counter to 1
        do_reset();
        chk("t8.cnt_rst", 32'(pkt_count), 32'h0);
        drive(0, 1'b1, 1'b1, 1'b1, 32'h1234_0000);
        repeat (34) tick();
        clear_all();
        tick();
        chk("t8.cnt_wrap", 32'(pkt_count), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t8.cnt_clr", 32'(pkt_count), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
